// File: rtl/vga_scanout_ctrl_if.sv
// Scan-out bus between the VGA controller, image memory, palette and video DAC.
// Latency: none (wires only).
// Backpressure: none; the video side is free-running at the pixel clock.
//
// Signals:
//   addr_imgmem  -> image memory address (controller drives)
//   q_imgmem     <- image memory read data (palette index)
//   pal_index    -> palette address (controller drives)
//   pal_data     <- palette BGR data, [23:16]=B [15:8]=G [7:0]=R
//   oHS/oVS/oBLANK_n/oFRAME_START, b/g/r_data -> video timing and colour
interface vga_scanout_ctrl_if #(
   parameter int ADDR_W  = 19,
   parameter int INDEX_W = 8
);
   logic [ADDR_W-1:0]  addr_imgmem;
   logic [INDEX_W-1:0] q_imgmem;
   logic [INDEX_W-1:0] pal_index;
   logic [23:0]        pal_data;
   logic               oHS;
   logic               oVS;
   logic               oBLANK_n;
   logic               oFRAME_START;
   logic [7:0]         b_data;
   logic [7:0]         g_data;
   logic [7:0]         r_data;

   modport master (
      output addr_imgmem, pal_index,
      output oHS, oVS, oBLANK_n, oFRAME_START, b_data, g_data, r_data,
      input  q_imgmem, pal_data
   );

   modport slave (
      input  addr_imgmem, pal_index,
      input  oHS, oVS, oBLANK_n, oFRAME_START, b_data, g_data, r_data,
      output q_imgmem, pal_data
   );
endinterface

// File: rtl/vga_scanout_ctrl.sv
// VGA raster scan-out: timing counters, image memory addressing, palette lookup.
// Latency: L = 2+MEM_LAT+PAL_LAT cycles from counter position to colour/sync outputs.
// Backpressure: none; iEN=0 parks the raster at (0,0) and flushes the pipeline to blank.
//
// Ports:
//   iVGA_CLK  pixel clock          iRST_n  async active-low reset
//   iEN       scan enable          bus     vga_scanout_ctrl_if.master (memory, palette, video out)
module vga_scanout_ctrl #(
   parameter int H_ACTIVE    = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter int SCALE_SHIFT = 0,
   parameter int ADDR_W      = 19,
   parameter int INDEX_W     = 8,
   parameter int MEM_LAT     = 1,
   parameter int PAL_LAT     = 1
) (
   input  logic               iVGA_CLK,
   input  logic               iRST_n,
   input  logic               iEN,
   vga_scanout_ctrl_if.master bus
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int L       = 2 + MEM_LAT + PAL_LAT;

   // One extra count of headroom so the sync end bound is always representable.
   localparam int HCNT_W = $clog2(H_TOTAL + 1);
   localparam int VCNT_W = $clog2(V_TOTAL + 1);
   localparam int REP_W  = (SCALE_SHIFT > 0) ? SCALE_SHIFT : 1;

   localparam logic [HCNT_W-1:0] H_LAST   = HCNT_W'(H_TOTAL - 1);
   localparam logic [HCNT_W-1:0] H_VIS    = HCNT_W'(H_ACTIVE);
   localparam logic [HCNT_W-1:0] HS_BEG   = HCNT_W'(H_ACTIVE + H_FP);
   localparam logic [HCNT_W-1:0] HS_END   = HCNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VCNT_W-1:0] V_LAST   = VCNT_W'(V_TOTAL - 1);
   localparam logic [VCNT_W-1:0] V_VIS    = VCNT_W'(V_ACTIVE);
   localparam logic [VCNT_W-1:0] VS_BEG   = VCNT_W'(V_ACTIVE + V_FP);
   localparam logic [VCNT_W-1:0] VS_END   = VCNT_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [REP_W-1:0]  REP_LAST = REP_W'((1 << SCALE_SHIFT) - 1);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_ACTIVE >> SCALE_SHIFT);

   if ((SCALE_SHIFT < 0) || (SCALE_SHIFT > 2) ||
       ((H_ACTIVE % (1 << SCALE_SHIFT)) != 0) ||
       ((V_ACTIVE % (1 << SCALE_SHIFT)) != 0) ||
       (64'((H_ACTIVE * V_ACTIVE) >> (2 * SCALE_SHIFT)) > (64'(1) << ADDR_W))) begin : g_param_err
      $error("vga_scanout_ctrl: bad SCALE_SHIFT / active size / ADDR_W combination");
   end

   typedef struct packed {
      logic hs;
      logic vs;
      logic blank_n;
      logic fs;
   } sync_t;

   localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0, fs: 1'b0};

   logic [HCNT_W-1:0] hcnt;
   logic [VCNT_W-1:0] vcnt;
   logic [ADDR_W-1:0] row_base;
   logic [REP_W-1:0]  rep_cnt;    // visible lines already emitted from the current row_base
   logic [ADDR_W-1:0] addr_q;
   logic [23:0]       col_q;
   sync_t             raw_sync;
   sync_t             sync_pipe [L];

   logic h_vis, v_vis, h_wrap, v_wrap;

   assign h_vis  = (hcnt < H_VIS);
   assign v_vis  = (vcnt < V_VIS);
   assign h_wrap = (hcnt == H_LAST);
   assign v_wrap = (vcnt == V_LAST);

   // Raster counters and incremental row base (no multiplier).
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         hcnt     <= '0;
         vcnt     <= '0;
         row_base <= '0;
         rep_cnt  <= '0;
      end else if (!iEN) begin
         hcnt     <= '0;
         vcnt     <= '0;
         row_base <= '0;
         rep_cnt  <= '0;
      end else if (h_wrap) begin
         hcnt <= '0;
         if (v_wrap) begin
            vcnt     <= '0;
            row_base <= '0;
            rep_cnt  <= '0;
         end else begin
            vcnt <= vcnt + VCNT_W'(1);
            if (v_vis) begin
               if (rep_cnt == REP_LAST) begin
                  rep_cnt  <= '0;
                  row_base <= row_base + ROW_STEP;
               end else begin
                  rep_cnt <= rep_cnt + REP_W'(1);
               end
            end
         end
      end else begin
         hcnt <= hcnt + HCNT_W'(1);
      end
   end

   // Address only moves inside the visible window; it parks on the last pixel fetched.
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         addr_q <= '0;
      end else if (iEN && h_vis && v_vis) begin
         addr_q <= row_base + ADDR_W'(hcnt >> SCALE_SHIFT);
      end
   end

   always_comb begin
      raw_sync = SYNC_IDLE;
      if (iEN) begin
         raw_sync.hs      = !((hcnt >= HS_BEG) && (hcnt < HS_END));
         raw_sync.vs      = !((vcnt >= VS_BEG) && (vcnt < VS_END));
         raw_sync.blank_n = h_vis && v_vis;
         raw_sync.fs      = (hcnt == '0) && (vcnt == '0);
      end
   end

   // Sync delay line. Dropping iEN flushes every stage so an aborted frame
   // leaves nothing in flight.
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         for (int k = 0; k < L; k++) sync_pipe[k] <= SYNC_IDLE;
      end else if (!iEN) begin
         for (int k = 0; k < L; k++) sync_pipe[k] <= SYNC_IDLE;
      end else begin
         sync_pipe[0] <= raw_sync;
         for (int k = 1; k < L; k++) sync_pipe[k] <= sync_pipe[k-1];
      end
   end

   // Colour register is gated by the blank bit that lands on the output
   // alongside it, so blanked cycles always present black.
   always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
      if (!iRST_n) begin
         col_q <= '0;
      end else if (iEN && sync_pipe[L-2].blank_n) begin
         col_q <= bus.pal_data;
      end else begin
         col_q <= '0;
      end
   end

   assign bus.addr_imgmem  = addr_q;
   assign bus.pal_index    = bus.q_imgmem;
   assign bus.oHS          = sync_pipe[L-1].hs;
   assign bus.oVS          = sync_pipe[L-1].vs;
   assign bus.oBLANK_n     = sync_pipe[L-1].blank_n;
   assign bus.oFRAME_START = sync_pipe[L-1].fs;
   assign bus.b_data       = col_q[23:16];
   assign bus.g_data       = col_q[15:8];
   assign bus.r_data       = col_q[7:0];

endmodule

// File: tb/tb_vga_scanout_ctrl.sv
// Directed bench for vga_scanout_ctrl: small 14x7 raster, unscaled and 2x scaled.
// Cycle c counts posedges since iEN was sampled high; outputs read at the following negedge.
// Colour/sync at cycle c belong to raster position c-4; addr_imgmem to position c-1.
module tb_vga_scanout_ctrl;

   localparam int AW = 19;
   localparam int IW = 8;
   localparam int TR = 200;

   logic iVGA_CLK = 1'b0;
   logic iRST_n   = 1'b1;
   logic iEN      = 1'b0;
   logic pal_white = 1'b0;

   always #5 iVGA_CLK = ~iVGA_CLK;

   vga_scanout_ctrl_if #(.ADDR_W(AW), .INDEX_W(IW)) bus0 ();
   vga_scanout_ctrl_if #(.ADDR_W(AW), .INDEX_W(IW)) bus1 ();

   vga_scanout_ctrl #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .SCALE_SHIFT(0), .ADDR_W(AW), .INDEX_W(IW), .MEM_LAT(1), .PAL_LAT(1)
   ) dut0 (
      .iVGA_CLK(iVGA_CLK), .iRST_n(iRST_n), .iEN(iEN), .bus(bus0)
   );

   vga_scanout_ctrl #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .SCALE_SHIFT(1), .ADDR_W(AW), .INDEX_W(IW), .MEM_LAT(1), .PAL_LAT(1)
   ) dut1 (
      .iVGA_CLK(iVGA_CLK), .iRST_n(iRST_n), .iEN(iEN), .bus(bus1)
   );

   // One-cycle image memory (index = address) and one-cycle palette ({i,i,i}).
   always @(posedge iVGA_CLK) begin
      bus0.q_imgmem <= bus0.addr_imgmem[7:0];
      bus0.pal_data <= pal_white ? 24'hFFFFFF : {3{bus0.pal_index}};
      bus1.q_imgmem <= bus1.addr_imgmem[7:0];
      bus1.pal_data <= {3{bus1.pal_index}};
   end

   int nvec = 0;
   int nmis = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   logic [AW-1:0] a0 [1:TR];
   logic [AW-1:0] a1 [1:TR];
   logic [7:0]    r0 [1:TR];
   logic [7:0]    g0 [1:TR];
   logic [7:0]    b0 [1:TR];
   logic [7:0]    r1 [1:TR];
   logic          bl0 [1:TR];
   logic          hs0 [1:TR];
   logic          vs0 [1:TR];
   logic          fs0 [1:TR];

   task automatic tick();
      @(posedge iVGA_CLK);
      @(negedge iVGA_CLK);
   endtask

   task automatic capture(input int n);
      for (int c = 1; c <= n; c++) begin
         tick();
         a0[c]  = bus0.addr_imgmem;
         a1[c]  = bus1.addr_imgmem;
         r0[c]  = bus0.r_data;
         g0[c]  = bus0.g_data;
         b0[c]  = bus0.b_data;
         r1[c]  = bus1.r_data;
         bl0[c] = bus0.oBLANK_n;
         hs0[c] = bus0.oHS;
         vs0[c] = bus0.oVS;
         fs0[c] = bus0.oFRAME_START;
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_blank"}, 32'(bus0.oBLANK_n), 0);
      chk({tag, "_hs"},    32'(bus0.oHS), 1);
      chk({tag, "_vs"},    32'(bus0.oVS), 1);
      chk({tag, "_rgb"},   32'({bus0.r_data, bus0.g_data, bus0.b_data}), 0);
   endtask

   initial begin
      int n_bl, n_hs, n_vs, n_fs, n_bad;
      logic [AW-1:0] s1_line [8];
      s1_line = '{0, 0, 1, 1, 2, 2, 3, 3};

      // Reset state.
      #2 iRST_n = 1'b0;
      repeat (3) @(negedge iVGA_CLK);
      chk_idle("rst");
      chk("rst_fs",    32'(bus0.oFRAME_START), 0);
      chk("rst_addr0", 32'(bus0.addr_imgmem), 0);
      chk("rst_addr1", 32'(bus1.addr_imgmem), 0);

      // Out of reset but disabled: pipeline keeps presenting idle values.
      iRST_n = 1'b1;
      repeat (3) tick();
      chk_idle("dis");

      // Main scan, two full frames.
      iEN = 1'b1;
      capture(TR);

      chk("a0_c1",   32'(a0[1]), 0);
      chk("a0_c8",   32'(a0[8]), 7);
      chk("a0_hold", 32'(a0[9]), 7);
      chk("a0_c15",  32'(a0[15]), 8);
      chk("a0_c22",  32'(a0[22]), 15);
      chk("a0_last", 32'(a0[50]), 31);
      chk("a0_vbl",  32'(a0[57]), 31);
      chk("a0_wrap", 32'(a0[99]), 0);
      chk("a0_c100", 32'(a0[100]), 1);

      chk("bl_c3",  32'(bl0[3]), 0);
      chk("bl_c4",  32'(bl0[4]), 1);
      chk("bl_c11", 32'(bl0[11]), 1);
      chk("bl_c12", 32'(bl0[12]), 0);
      chk("bl_c18", 32'(bl0[18]), 1);
      for (int i = 0; i < 8; i++) chk($sformatf("r_line0_%0d", i), 32'(r0[4+i]), i);
      chk("r_c12",   32'(r0[12]), 0);
      chk("r_c18",   32'(r0[18]), 8);
      chk("r_c53",   32'(r0[53]), 31);
      chk("g_c11",   32'(g0[11]), 7);
      chk("b_c11",   32'(b0[11]), 7);

      chk("hs_c13", 32'(hs0[13]), 1);
      chk("hs_c14", 32'(hs0[14]), 0);
      chk("hs_c15", 32'(hs0[15]), 0);
      chk("hs_c16", 32'(hs0[16]), 1);
      chk("vs_c73", 32'(vs0[73]), 1);
      chk("vs_c74", 32'(vs0[74]), 0);
      chk("vs_c87", 32'(vs0[87]), 0);
      chk("vs_c88", 32'(vs0[88]), 1);
      chk("fs_c4",   32'(fs0[4]), 1);
      chk("fs_c5",   32'(fs0[5]), 0);
      chk("fs_c102", 32'(fs0[102]), 1);

      n_bl = 0; n_hs = 0; n_vs = 0; n_fs = 0; n_bad = 0;
      for (int c = 4; c <= 101; c++) begin
         n_bl += int'(bl0[c]);
         n_hs += int'(!hs0[c]);
         n_vs += int'(!vs0[c]);
         if (!bl0[c] && ({r0[c], g0[c], b0[c]} != 24'h0)) n_bad++;
      end
      for (int c = 1; c <= 199; c++) n_fs += int'(fs0[c]);
      chk("cnt_blank_frame", 32'(n_bl), 32);
      chk("cnt_hs_low",      32'(n_hs), 14);
      chk("cnt_vs_low",      32'(n_vs), 14);
      chk("cnt_fs_2frames",  32'(n_fs), 2);
      chk("blank_rgb_zero",  32'(n_bad), 0);

      // 2x scaled instance.
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("s1_l0_%0d", i), 32'(a1[1+i]),  32'(s1_line[i]));
         chk($sformatf("s1_l1_%0d", i), 32'(a1[15+i]), 32'(s1_line[i]));
      end
      chk("s1_l2_first", 32'(a1[29]), 4);
      chk("s1_l2_last",  32'(a1[36]), 7);
      chk("s1_l3_first", 32'(a1[43]), 4);
      chk("s1_last",     32'(a1[50]), 7);
      chk("s1_wrap",     32'(a1[99]), 0);
      chk("s1_r_c4",     32'(r1[4]), 0);
      chk("s1_r_c6",     32'(r1[6]), 1);

      // Asynchronous reset in the middle of line 2 (position v2,h3).
      repeat (28) tick();
      chk("pre_rst_blank", 32'(bus0.oBLANK_n), 1);
      chk("pre_rst_r",     32'(bus0.r_data), 16);
      iRST_n = 1'b0;
      #1;
      chk_idle("async_rst");
      chk("async_rst_addr", 32'(bus0.addr_imgmem), 0);
      repeat (3) @(negedge iVGA_CLK);
      iRST_n = 1'b1;
      capture(12);
      chk("rst_restart_bl3", 32'(bl0[3]), 0);
      chk("rst_restart_a1",  32'(a0[1]), 0);
      chk("rst_restart_fs3", 32'(fs0[3]), 0);
      chk("rst_restart_fs4", 32'(fs0[4]), 1);
      chk("rst_restart_bl4", 32'(bl0[4]), 1);
      chk("rst_restart_r4",  32'(r0[4]), 0);
      chk("rst_restart_r5",  32'(r0[5]), 1);

      // Drop iEN in line 1 (outputs currently show position v1,h0), re-enable 5 cycles later.
      repeat (6) tick();
      chk("pre_dis_r", 32'(bus0.r_data), 8);
      iEN = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_idle($sformatf("abort%0d", i));
      end
      iEN = 1'b1;
      capture(12);
      for (int i = 0; i < 8; i++) chk($sformatf("reen_addr%0d", i), 32'(a0[1+i]), i);
      chk("reen_fs4",  32'(fs0[4]), 1);
      chk("reen_bl3",  32'(bl0[3]), 0);
      chk("reen_r4",   32'(r0[4]), 0);

      // White palette: colour is FF on visible pixels and 0 elsewhere.
      pal_white = 1'b1;
      repeat (4) tick();
      capture(98);
      n_bl = 0; n_bad = 0;
      for (int c = 1; c <= 98; c++) begin
         n_bl += int'(bl0[c]);
         if (bl0[c] && ({r0[c], g0[c], b0[c]} != 24'hFFFFFF)) n_bad++;
         if (!bl0[c] && ({r0[c], g0[c], b0[c]} != 24'h000000)) n_bad++;
      end
      chk("white_blank_cnt", 32'(n_bl), 32);
      chk("white_rgb_bad",   32'(n_bad), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
